pulse_receiver: RTL

- Capture-side counterpart of the pulse transmitter. Samples an asynchronous input pin and measures each high and low segment in prescaled ticks.
- Each completed segment is pushed as a {level, duration} symbol into a small FIFO, which the peripheral register interface pops.
- A frame ends on a low segment reaching the idle threshold. The block then sets a sticky frame-done flag.

---
 rtl/pulse_receiver.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pulse_receiver.sv
// pulse_receiver: measures synchronized pin segments in prescaled ticks
// and queues {level, duration} symbols in a small FIFO for readback.
//
// Ports:
//   clk, sys_rst_n       clock, async active-low reset
//   enable               receiver enable; low drops any partial segment
//   prescaler            tick period = 2^prescaler clk cycles
//   invert               1 = pin idles high
//   idle_threshold       low-segment ticks that end a frame (0 = off)
//   pulse_in             asynchronous input pin
//   rd_en                pop FIFO head
//   rd_data, rd_valid    head symbol {level, duration} (0 when empty)
//   fifo_count           entries held
//   overflow             sticky: symbol dropped on full FIFO
//   frame_done           sticky: idle timeout ended a frame
//   clear_flags          clears overflow and frame_done
//   busy                 measuring a frame
module pulse_receiver #(
    parameter int PRESCALER_NUM_BITS = 4,
    parameter int DURATION_BITS      = 8,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                          clk,
    input  logic                          sys_rst_n,
    input  logic                          enable,
    input  logic [PRESCALER_NUM_BITS-1:0] prescaler,
    input  logic                          invert,
    input  logic [DURATION_BITS-1:0]      idle_threshold,
    input  logic                          pulse_in,
    input  logic                          rd_en,
    output logic [DURATION_BITS:0]        rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_done,
    input  logic                          clear_flags,
    output logic                          busy
);

    localparam int PW = 1 << PRESCALER_NUM_BITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = DURATION_BITS + 1;
    localparam logic [DURATION_BITS-1:0] DUR_MAX = '1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t                   state_q, state_d;
    logic                     sync1_q, sync1_d;
    logic                     sync2_q, sync2_d;
    logic [1:0]               sync_ok_q, sync_ok_d;
    logic                     prev_lvl_q, prev_lvl_d;
    logic [PW-1:0]            phase_q, phase_d;
    logic [DURATION_BITS-1:0] dur_q, dur_d;
    logic                     armed_q, armed_d;
    logic                     seg_level_q, seg_level_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic                     frame_done_q, frame_done_d;

    logic [SW-1:0]            mem [FIFO_DEPTH];

    logic                     lvl;
    logic                     edge_det;
    logic                     tick;
    logic [PW-1:0]            period;
    logic [PW-1:0]            phase_next;
    logic [DURATION_BITS-1:0] dur_base;
    logic [DURATION_BITS-1:0] dur_new;
    logic                     push;
    logic [SW-1:0]            push_data;
    logic                     fd_set;
    logic                     pop;
    logic                     wr;
    logic                     drop;

    always_comb begin
        lvl        = sync2_q ^ invert;
        edge_det   = lvl != prev_lvl_q;
        sync1_d    = pulse_in;
        sync2_d    = sync1_q;
        // Arming waits until the synchronizer holds a real pin sample,
        // so its reset value is never mistaken for an idle pin.
        sync_ok_d  = {sync_ok_q[0], 1'b1};
        prev_lvl_d = lvl;

        // Edge cycle is the first cycle of the new segment.
        period     = PW'(1) << prescaler;
        phase_next = (edge_det ? '0 : phase_q) + PW'(1);
        tick       = phase_next == period;
        phase_d    = tick ? '0 : phase_next;
        dur_base   = edge_det ? '0 : dur_q;
        dur_new    = (tick && dur_base != DUR_MAX)
                   ? dur_base + DURATION_BITS'(1) : dur_base;
        dur_d      = dur_new;

        state_d     = state_q;
        armed_d     = armed_q;
        seg_level_d = seg_level_q;
        push        = 1'b0;
        push_data   = '0;
        fd_set      = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            armed_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!lvl && sync_ok_q[1])
                        armed_d = 1'b1;
                    if (armed_q && edge_det && lvl) begin
                        state_d     = MEASURE;
                        seg_level_d = 1'b1;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        push        = 1'b1;
                        push_data   = {seg_level_q, dur_q};
                        seg_level_d = lvl;
                    end else if (tick && !seg_level_q &&
                                 idle_threshold != '0 &&
                                 dur_new >= idle_threshold) begin
                        push      = 1'b1;
                        push_data = {1'b0, idle_threshold};
                        fd_set    = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        pop  = rd_en && count_q != '0;
        // A full FIFO still accepts a push when a pop frees a slot.
        wr   = push && (count_q != FULL || pop);
        drop = push && count_q == FULL && !pop;

        wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr) - CW'(pop);

        overflow_d   = drop   || (overflow_q   && !clear_flags);
        frame_done_d = fd_set || (frame_done_q && !clear_flags);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync_ok_q    <= '0;
            prev_lvl_q   <= 1'b0;
            phase_q      <= '0;
            dur_q        <= '0;
            armed_q      <= 1'b0;
            seg_level_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync_ok_q    <= sync_ok_d;
            prev_lvl_q   <= prev_lvl_d;
            phase_q      <= phase_d;
            dur_q        <= dur_d;
            armed_q      <= armed_d;
            seg_level_q  <= seg_level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr_q] <= push_data;
    end

    assign rd_valid   = count_q != '0;
    assign rd_data    = rd_valid ? mem[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;
    assign busy       = state_q == MEASURE;

endmodule
